i2s_mic_rx: RTL and testbench
=============================

# i2s_mic_rx

I2S master receiver for a mono MEMS microphone on the SoC's audio port. It generates the bit clock (SCK) and word select (WS), and samples serial data (SD) for the left channel. Each sample is sign-extended and buffered in a small FIFO that the SoC bus slave or a DMA reads. Its pins are the SoC's SCK/WS/SD outputs and inputs; on the bench, the I2S microphone model drives SD.

## Interface
- CLK_DIV, 2: HCLK cycles per SCK half-period, minimum 1.
- DATA_W, 24: valid sample bits per slot, range 8..31.
- FIFO_DEPTH, 8: sample entries, power of 2.
- HCLK  in  1  system clock; all logic on rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- en  in  1  capture enable.
- SD  in  1  serial data from the microphone.
- SCK  out  1  I2S bit clock.
- WS  out  1  word select; 0 = left slot, 1 = right slot.
- rd_en  in  1  pop strobe; ignored when empty.
- rd_data  out  32  FIFO head, first-word-fall-through, sign-extended sample.
- empty  out  1  FIFO empty.
- level  out  log2(FIFO_DEPTH)+1  entries held.
- ovf  out  1  sticky overflow flag.
- clr_ovf  in  1  clears ovf.

## Operation
- Clock divider: dcnt counts 0..CLK_DIV-1. At terminal count, SCK toggles and dcnt returns to 0.
  - A toggle from 0 to 1 is a rise event.
  - A toggle from 1 to 0 is a fall event.
- Frame: bcnt (6 bits) holds the SCK cycle index 0..63.
  - bcnt increments mod 64 on each fall event.
  - WS = bcnt[5], registered together with bcnt, so WS changes only on the SCK falling edge.
- Capture: on a rise event with 1 ≤ bcnt ≤ DATA_W and WS = 0, SD shifts into sreg MSB-first (I2S one-bit delay after the WS edge).
  - On the rise event with bcnt == DATA_W, the sample is complete and wr_req is set for exactly one HCLK.
  - Right-slot bits and slot bits past DATA_W are ignored.
- Write: when wr_req = 1, {{(32-DATA_W){sreg[DATA_W-1]}}, sreg} is written to the FIFO unless the FIFO is full.
  - If full, the sample is dropped and ovf is set to 1.
- Read: rd_en with empty = 0 advances the read pointer.
  - rd_en with empty = 1 has no effect.
- Simultaneous write and read:
  - both occur in the same cycle and level is unchanged;
  - when full, the write is accepted, because the read frees the slot, and ovf is not set.
- ovf: once set, it stays 1 until clr_ovf = 1. If clr_ovf and an overflow occur in the same cycle, ovf = 1 (set wins).
- en = 0:
  - dcnt = 0, bcnt = 0, SCK = 0, WS = 0;
  - sreg cleared and any pending capture discarded;
  - FIFO contents, level and ovf are preserved; reads stay functional.
- en 0→1: the frame restarts at bcnt = 0. The first rise event occurs CLK_DIV cycles later.
- Pointers: wptr and rptr are (log2(FIFO_DEPTH)+1) bits and wrap naturally. The extra MSB distinguishes full from empty.
  - level = wptr - rptr.
  - full when level == FIFO_DEPTH.

## Timing
- Reset values: SCK = 0, WS = 0, empty = 1, level = 0, ovf = 0, rd_data = 0.
- Reset also clears dcnt, bcnt, sreg, wr_req and both pointers.
- Reset asserted mid-frame aborts the frame immediately. FIFO contents are discarded.
- SCK period = 2·CLK_DIV HCLK cycles. Frame = 64 SCK periods = 128·CLK_DIV HCLK cycles (256 at default).
- Latency from the LSB rise event to empty = 0 and valid rd_data is 2 HCLK cycles:
  - 1 cycle for wr_req;
  - 1 cycle for the FIFO write.
- The rd_en pop takes effect at the next HCLK edge. The next head appears on rd_data in that same cycle.

## Test plan
- Reset then en = 1, CLK_DIV = 2:
  - SCK toggles every 2 HCLK;
  - WS rises after 32 SCK periods and falls after 64;
  - all outputs hold reset values during reset.
- Mic model drives left 24'hA5F00F and right 24'h123456:
  - one entry per frame, rd_data = 32'hFFA5F00F;
  - the right sample never appears.
- Left 24'h123456 → rd_data = 32'h00123456. The entry is visible 2 HCLK after the 24th capture rise.
- No reads for 9 frames with FIFO_DEPTH = 8:
  - level = 8, ovf = 1;
  - the first 8 samples read back in order.
  - Then clr_ovf → ovf = 0.
- FIFO full and rd_en pulsed in the write cycle: level stays 8, ovf stays 0, and the newest sample is retained.
- Deassert en at bcnt = 10, then reassert:
  - no partial sample is written;
  - SCK and WS restart from frame start;
  - the next full frame yields the correct sample.
- A mid-frame HRESETn pulse gives immediate reset values, and the FIFO is empty.

Source files
------------

// File: rtl/i2s_mic_rx_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | i2s_mic_rx_if : sample FIFO read port and overflow status of i2s_mic_rx    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface i2s_mic_rx_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int c_lvl_w = $clog2(FIFO_DEPTH) + 1;

  logic               rd_en;
  logic [31:0]        rd_data;
  logic               empty;
  logic [c_lvl_w-1:0] level;
  logic               ovf;
  logic               clr_ovf;

  modport master (
    output rd_en,
    output clr_ovf,
    input  rd_data,
    input  empty,
    input  level,
    input  ovf
  );

  modport slave (
    input  rd_en,
    input  clr_ovf,
    output rd_data,
    output empty,
    output level,
    output ovf
  );
endinterface
`default_nettype wire

// File: rtl/i2s_mic_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | i2s_mic_rx : I2S master receiver for a mono (left-slot) MEMS microphone    |
// |              with a sign-extending first-word-fall-through sample FIFO     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module i2s_mic_rx #(
  parameter int CLK_DIV    = 2,
  parameter int DATA_W     = 24,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        en,
  input  logic        SD,
  output logic        SCK,
  output logic        WS,
  i2s_mic_rx_if.slave bus
);
  localparam int c_dcnt_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int c_aw     = $clog2(FIFO_DEPTH);
  localparam int c_lvl_w  = c_aw + 1;
  localparam logic [c_dcnt_w-1:0] c_dcnt_last = c_dcnt_w'(CLK_DIV - 1);
  localparam logic [5:0]          c_last_bit  = 6'(DATA_W);
  localparam logic [c_lvl_w-1:0]  c_full      = c_lvl_w'(FIFO_DEPTH);

  logic [c_dcnt_w-1:0] r_dcnt;
  logic                r_sck;
  logic [5:0]          r_bcnt;
  logic [DATA_W-1:0]   r_sreg;
  logic                r_wr_req;
  logic [c_lvl_w-1:0]  r_wptr;
  logic [c_lvl_w-1:0]  r_rptr;
  logic                r_ovf;
  logic [31:0]         r_mem [FIFO_DEPTH];

  logic               w_tick;
  logic               w_rise;
  logic               w_fall;
  logic               w_cap;
  logic [c_lvl_w-1:0] w_level;
  logic               w_empty;
  logic               w_full;
  logic               w_rd;
  logic               w_wr_try;
  logic               w_wr;
  logic               w_ovf_set;

  assign w_tick = en && (r_dcnt == c_dcnt_last);
  assign w_rise = w_tick && !r_sck;
  assign w_fall = w_tick && r_sck;
  // Slot bit 0 is the I2S one-bit delay; bits 1..DATA_W carry the sample MSB first.
  assign w_cap  = w_rise && !r_bcnt[5] && (r_bcnt != 6'd0) && (r_bcnt <= c_last_bit);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_dcnt   <= '0;
      r_sck    <= 1'b0;
      r_bcnt   <= 6'd0;
      r_sreg   <= '0;
      r_wr_req <= 1'b0;
    end else if (!en) begin
      r_dcnt   <= '0;
      r_sck    <= 1'b0;
      r_bcnt   <= 6'd0;
      r_sreg   <= '0;
      r_wr_req <= 1'b0;
    end else begin
      r_wr_req <= w_cap && (r_bcnt == c_last_bit);
      if (w_tick) begin
        r_dcnt <= '0;
        r_sck  <= ~r_sck;
      end else begin
        r_dcnt <= r_dcnt + 1'b1;
      end
      if (w_fall) begin
        r_bcnt <= r_bcnt + 6'd1;
      end
      if (w_cap) begin
        r_sreg <= {r_sreg[DATA_W-2:0], SD};
      end
    end
  end

  assign w_level   = r_wptr - r_rptr;
  assign w_empty   = (w_level == '0);
  assign w_full    = (w_level == c_full);
  assign w_rd      = bus.rd_en && !w_empty;
  // A capture still pending when en drops is discarded, not written.
  assign w_wr_try  = r_wr_req && en;
  assign w_wr      = w_wr_try && (!w_full || w_rd);
  assign w_ovf_set = w_wr_try && w_full && !w_rd;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_rd) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (bus.clr_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (w_wr) begin
      r_mem[r_wptr[c_aw-1:0]] <= {{(32-DATA_W){r_sreg[DATA_W-1]}}, r_sreg};
    end
  end

  assign SCK         = r_sck;
  assign WS          = r_bcnt[5];
  assign bus.rd_data = w_empty ? 32'd0 : r_mem[r_rptr[c_aw-1:0]];
  assign bus.empty   = w_empty;
  assign bus.level   = w_level;
  assign bus.ovf     = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_i2s_mic_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_i2s_mic_rx : self-checking bench with I2S microphone model and         |
// |                 frame-arithmetic reference model of i2s_mic_rx             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_i2s_mic_rx;
  localparam int CLK_DIV    = 2;
  localparam int DATA_W     = 24;
  localparam int FIFO_DEPTH = 8;
  localparam int FRAME      = 128 * CLK_DIV;

  logic HCLK    = 1'b0;
  logic HRESETn = 1'b0;
  logic en      = 1'b0;
  logic SD      = 1'b0;
  logic SCK;
  logic WS;

  i2s_mic_rx_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

  i2s_mic_rx #(
    .CLK_DIV   (CLK_DIV),
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .HCLK   (HCLK),
    .HRESETn(HRESETn),
    .en     (en),
    .SD     (SD),
    .SCK    (SCK),
    .WS     (WS),
    .bus    (bus)
  );

  always #5 HCLK = ~HCLK;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sext(input logic [DATA_W-1:0] v);
    return {{(32-DATA_W){v[DATA_W-1]}}, v};
  endfunction

  // Reference model: k = enabled HCLK edges since frame start; everything else follows from k.
  int                k = 0;
  logic [31:0]       mq[$];
  logic              m_ovf = 1'b0;
  logic              pend = 1'b0;
  logic [31:0]       pend_val = '0;
  logic [DATA_W-1:0] cur_left = '0;
  logic [DATA_W-1:0] cur_right = '0;
  logic [DATA_W-1:0] left_q[$];
  logic              use_fixed_right = 1'b0;
  logic [DATA_W-1:0] fixed_right = '0;

  always @(posedge HCLK) begin
    logic en_s, rd_s, clr_s, rst_s, pop, wr, full_b;
    en_s  = en;
    rd_s  = bus.rd_en;
    clr_s = bus.clr_ovf;
    rst_s = HRESETn;
    #1;
    if (!rst_s) begin
      k = 0;
      mq.delete();
      m_ovf = 1'b0;
      pend  = 1'b0;
    end else begin
      pop    = rd_s && (mq.size() > 0);
      full_b = (mq.size() == FIFO_DEPTH);
      wr     = pend && en_s;
      if (pop) void'(mq.pop_front());
      if (wr && (!full_b || pop)) mq.push_back(pend_val);
      if (wr && full_b && !pop) m_ovf = 1'b1;
      else if (clr_s) m_ovf = 1'b0;
      pend = 1'b0;
      if (en_s) begin
        k++;
        if ((k % (2*CLK_DIV) == CLK_DIV) && ((k / (2*CLK_DIV)) % 64 == DATA_W)) begin
          pend     = 1'b1;
          pend_val = sext(cur_left);
        end
        if (k % FRAME == 1) begin
          if (left_q.size() > 0) cur_left = left_q.pop_front();
          else cur_left = DATA_W'($urandom);
          cur_right = use_fixed_right ? fixed_right : DATA_W'($urandom);
        end
      end else begin
        k = 0;
      end
    end
    check("SCK", 32'(SCK), 32'((k / CLK_DIV) % 2));
    check("WS", 32'(WS), 32'((k / (64*CLK_DIV)) % 2));
    check("empty", 32'(bus.empty), 32'(mq.size() == 0));
    check("level", 32'(bus.level), 32'(mq.size()));
    check("rd_data", bus.rd_data, (mq.size() > 0) ? mq[0] : 32'd0);
    check("ovf", 32'(bus.ovf), 32'(m_ovf));
  end

  // Microphone: drives the slot bit for the current SCK cycle; unused bits are noise.
  always @(negedge HCLK) begin
    int b;
    b = (k / (2*CLK_DIV)) % 64;
    if (b >= 1 && b <= DATA_W) SD = cur_left[DATA_W-b];
    else if (b >= 33 && b <= 32 + DATA_W) SD = cur_right[DATA_W-(b-32)];
    else SD = 1'($urandom);
  end

  typedef struct {
    logic [DATA_W-1:0] left;
    logic [31:0]       exp;
  } vec_t;

  vec_t              vecs[6];
  logic [DATA_W-1:0] vals[9];

  task automatic drain();
    for (int n = 0; n < 2*FIFO_DEPTH + 2 && !bus.empty; n++) begin
      bus.rd_en = 1'b1;
      @(negedge HCLK);
    end
    bus.rd_en = 1'b0;
  endtask

  task automatic wait_entry(input string name);
    for (int n = 0; n < 2*FRAME && bus.empty; n++) @(negedge HCLK);
    check(name, 32'(bus.empty), 32'd0);
  endtask

  task automatic pop_check(input string name, input logic [31:0] exp);
    check(name, bus.rd_data, exp);
    bus.rd_en = 1'b1;
    @(negedge HCLK);
    bus.rd_en = 1'b0;
  endtask

  initial begin
    bit hit;
    bus.rd_en   = 1'b0;
    bus.clr_ovf = 1'b0;
    vecs[0] = '{24'hA5F00F, 32'hFFA5F00F};
    vecs[1] = '{24'h123456, 32'h00123456};
    vecs[2] = '{24'h800000, 32'hFF800000};
    vecs[3] = '{24'h7FFFFF, 32'h007FFFFF};
    vecs[4] = '{24'h000001, 32'h00000001};
    vecs[5] = '{24'hFFFFFF, 32'hFFFFFFFF};

    repeat (3) @(negedge HCLK);
    check("rst_SCK", 32'(SCK), 32'd0);
    check("rst_WS", 32'(WS), 32'd0);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_level", 32'(bus.level), 32'd0);
    check("rst_ovf", 32'(bus.ovf), 32'd0);
    check("rst_rd_data", bus.rd_data, 32'd0);
    HRESETn = 1'b1;
    @(negedge HCLK);

    // Two identical frames per vector: exactly one entry per frame, right slot never stored.
    use_fixed_right = 1'b1;
    fixed_right     = 24'h123456;
    for (int i = 0; i < 6; i++) begin
      en = 1'b0;
      drain();
      left_q.push_back(vecs[i].left);
      left_q.push_back(vecs[i].left);
      @(negedge HCLK);
      en = 1'b1;
      wait_entry("vec_entry");
      check("vec_data", bus.rd_data, vecs[i].exp);
      check("vec_level1", 32'(bus.level), 32'd1);
      repeat (FRAME + 8) @(negedge HCLK);
      check("vec_level2", 32'(bus.level), 32'd2);
      pop_check("vec_pop1", vecs[i].exp);
      pop_check("vec_pop2", vecs[i].exp);
    end
    use_fixed_right = 1'b0;

    // Latency: write visible two HCLK edges after the LSB rise-event cycle.
    en = 1'b0;
    drain();
    left_q.push_back(24'h123456);
    @(negedge HCLK);
    en = 1'b1;
    hit = 1'b0;
    for (int n = 0; n < 2*FRAME; n++) begin
      @(negedge HCLK);
      if (pend) begin hit = 1'b1; break; end
    end
    check("lat_wait", 32'(hit), 32'd1);
    check("lat_sck_high", 32'(SCK), 32'd1);
    check("lat_empty_early", 32'(bus.empty), 32'd1);
    @(negedge HCLK);
    check("lat_empty", 32'(bus.empty), 32'd0);
    check("lat_data", bus.rd_data, 32'h00123456);

    // Overflow: nine frames without reads.
    en = 1'b0;
    drain();
    for (int i = 0; i < 9; i++) begin
      vals[i] = DATA_W'($urandom);
      left_q.push_back(vals[i]);
    end
    @(negedge HCLK);
    en = 1'b1;
    repeat (9*FRAME + 10) @(negedge HCLK);
    check("ovf_level", 32'(bus.level), 32'd8);
    check("ovf_flag", 32'(bus.ovf), 32'd1);
    for (int i = 0; i < 8; i++) pop_check("ovf_order", sext(vals[i]));
    bus.clr_ovf = 1'b1;
    @(negedge HCLK);
    bus.clr_ovf = 1'b0;
    check("ovf_clr", 32'(bus.ovf), 32'd0);

    // Full FIFO with a read in the write cycle: newest sample kept, no overflow.
    en = 1'b0;
    drain();
    for (int i = 0; i < 9; i++) begin
      vals[i] = DATA_W'($urandom);
      left_q.push_back(vals[i]);
    end
    @(negedge HCLK);
    en = 1'b1;
    hit = 1'b0;
    for (int n = 0; n < 10*FRAME; n++) begin
      @(negedge HCLK);
      if (pend && mq.size() == FIFO_DEPTH) begin hit = 1'b1; break; end
    end
    check("sim_wait", 32'(hit), 32'd1);
    bus.rd_en = 1'b1;
    @(negedge HCLK);
    bus.rd_en = 1'b0;
    en = 1'b0;
    check("sim_level", 32'(bus.level), 32'd8);
    check("sim_ovf", 32'(bus.ovf), 32'd0);
    for (int i = 1; i < 9; i++) pop_check("sim_order", sext(vals[i]));

    // en dropped mid-sample at bcnt 10, then a clean frame.
    drain();
    left_q.push_back(24'h5A5A5A);
    @(negedge HCLK);
    en = 1'b1;
    hit = 1'b0;
    for (int n = 0; n < 2*FRAME; n++) begin
      @(negedge HCLK);
      if ((k / (2*CLK_DIV)) % 64 == 10) begin hit = 1'b1; break; end
    end
    check("endrop_wait", 32'(hit), 32'd1);
    en = 1'b0;
    @(negedge HCLK);
    check("endrop_SCK", 32'(SCK), 32'd0);
    check("endrop_WS", 32'(WS), 32'd0);
    repeat (FRAME) @(negedge HCLK);
    check("endrop_no_partial", 32'(bus.empty), 32'd1);
    left_q.push_back(24'h9ABCDE);
    en = 1'b1;
    wait_entry("endrop_entry");
    check("endrop_data", bus.rd_data, 32'hFF9ABCDE);
    check("endrop_level", 32'(bus.level), 32'd1);

    // Randomised reads, clears and short en drops at several read rates.
    for (int seg = 0; seg < 4; seg++) begin
      int thr;
      thr = (seg == 0) ? 0 : (seg == 1) ? 2 : (seg == 2) ? 6 : 250;
      for (int n = 0; n < 6*FRAME; n++) begin
        bus.rd_en   = ($urandom_range(999) < thr);
        bus.clr_ovf = ($urandom_range(199) == 0);
        en          = ($urandom_range(1999) != 0);
        @(negedge HCLK);
      end
    end
    bus.rd_en   = 1'b0;
    bus.clr_ovf = 1'b0;
    en          = 1'b1;

    // Mid-frame asynchronous reset.
    wait_entry("rst_fill");
    repeat (37) @(negedge HCLK);
    HRESETn = 1'b0;
    #1;
    check("mid_rst_SCK", 32'(SCK), 32'd0);
    check("mid_rst_WS", 32'(WS), 32'd0);
    check("mid_rst_empty", 32'(bus.empty), 32'd1);
    check("mid_rst_level", 32'(bus.level), 32'd0);
    check("mid_rst_ovf", 32'(bus.ovf), 32'd0);
    check("mid_rst_rd_data", bus.rd_data, 32'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (FRAME + 20) @(negedge HCLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
